// File: rtl/fetch_ibuf_queue.sv
// Instruction byte queue between I$ line fetch and decode: DEPTH-line circular store
// with a byte-aligned PKT_BYTES window at the read pointer, resteer flush and fault tagging.
module fetch_ibuf_queue #(
  parameter int LINE_BYTES = 16,
  parameter int DEPTH      = 4,
  parameter int PKT_BYTES  = 16,
  localparam int OW = $clog2(LINE_BYTES),
  localparam int PW = $clog2(DEPTH * LINE_BYTES)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [LINE_BYTES*8-1:0] line_in,
  input  logic                    line_in_fault,
  input  logic                    line_in_valid,
  output logic                    line_in_ready,
  input  logic                    flush,
  input  logic [OW-1:0]           flush_offset,
  output logic [PKT_BYTES*8-1:0]  packet_out,
  output logic                    packet_valid,
  output logic                    packet_fault,
  input  logic [7:0]              D_length,
  input  logic                    stall,
  output logic [PW:0]             bytes_avail,
  output logic [PW-1:0]           BIP
);
  localparam int IW = $clog2(DEPTH);
  localparam int NB = DEPTH * LINE_BYTES;

  logic [7:0]      store [NB];
  logic [DEPTH-1:0] fault;
  logic [IW-1:0]   wr_idx, rd_idx;
  logic [IW:0]     count;
  logic [OW-1:0]   rd_off, pend_off;
  logic            pend_flag;

  logic            head_fault, enq, deq, freed;
  logic [7:0]      adv;
  logic [OW:0]     off_sum;

  always_comb begin
    bytes_avail   = '0;
    if (count != '0)
      bytes_avail = {count, {OW{1'b0}}} - (PW+1)'(rd_off);
    BIP           = {rd_idx, rd_off};
    head_fault    = (count != '0) && fault[rd_idx];
    packet_fault  = head_fault;
    line_in_ready = count < (IW+1)'(DEPTH);
    packet_valid  = (bytes_avail >= (PW+1)'(PKT_BYTES)) || head_fault;
    enq           = line_in_valid && line_in_ready && !flush;
    // A faulted head is never consumed; decode sees it until flush or reset.
    deq           = packet_valid && !stall && !flush && !head_fault;
    adv           = (D_length > 8'(PKT_BYTES)) ? 8'(PKT_BYTES) : D_length;
    off_sum       = {1'b0, rd_off} + (OW+1)'(adv);
    freed         = deq && off_sum[OW];
    packet_out    = '0;
    // Address arithmetic modulo the whole store keeps the window contiguous across wrap.
    for (int unsigned i = 0; i < PKT_BYTES; i++)
      packet_out[i*8 +: 8] = store[PW'({rd_idx, rd_off} + PW'(i))];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count     <= '0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      rd_off    <= '0;
      pend_off  <= '0;
      pend_flag <= 1'b0;
      fault     <= '0;
      for (int unsigned k = 0; k < NB; k++)
        store[k] <= '0;
    end else if (flush) begin
      count     <= '0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      rd_off    <= '0;
      pend_off  <= flush_offset;
      pend_flag <= 1'b1;
    end else begin
      if (enq) begin
        for (int unsigned j = 0; j < LINE_BYTES; j++)
          store[{wr_idx, OW'(j)}] <= line_in[j*8 +: 8];
        fault[wr_idx] <= line_in_fault;
        wr_idx        <= wr_idx + 1'b1;
        if (pend_flag) begin
          if (count == '0)
            rd_off <= pend_off;
          pend_flag <= 1'b0;
        end
      end
      // deq requires count>0, so it never collides with the pending-offset load above.
      if (deq) begin
        rd_off <= off_sum[OW-1:0];
        if (off_sum[OW])
          rd_idx <= rd_idx + 1'b1;
      end
      count <= count + (IW+1)'(enq) - (IW+1)'(freed);
    end
  end
endmodule
